// File: rtl/vx_tensor_octet_seq.sv
// vx_tensor_octet_seq: HMMA octet computing D = C + A*B over NUM_PARTS
// operand beats from one locked warp; results queue under output credits.
// Ports: clk/reset; in_* operand beat (valid/ready, wid, part, A/B/C, tag);
// out_* writeback beat (valid/ready, wid, tag, beat, last, data); busy; err.
module vx_tensor_octet_seq #(
  parameter int NUM_WARPS   = 4,
  parameter int M           = 4,
  parameter int N           = 4,
  parameter int KP          = 2,
  parameter int NUM_PARTS   = 2,
  parameter int WB_BEATS    = 2,
  parameter int DPU_LATENCY = 2,
  parameter int OUT_DEPTH   = 2,
  parameter int DATAW       = 32,
  parameter int TAGW        = 8,
  localparam int WIDW = NUM_WARPS > 1 ? $clog2(NUM_WARPS) : 1,
  localparam int PW   = NUM_PARTS > 1 ? $clog2(NUM_PARTS) : 1,
  localparam int BW   = WB_BEATS > 1 ? $clog2(WB_BEATS) : 1,
  localparam int CPP  = M * N / NUM_PARTS,
  localparam int EPB  = M * N / WB_BEATS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDW-1:0]       in_wid,
  input  logic [PW-1:0]         in_part,
  input  logic [M*KP*DATAW-1:0] in_a,
  input  logic [KP*N*DATAW-1:0] in_b,
  input  logic [CPP*DATAW-1:0]  in_c,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDW-1:0]       out_wid,
  output logic [TAGW-1:0]       out_tag,
  output logic [BW-1:0]         out_beat,
  output logic                  out_last,
  output logic [EPB*DATAW-1:0]  out_data,
  output logic                  busy,
  output logic                  err
);

  localparam int A_W = M * KP * DATAW;
  localparam int B_W = KP * N * DATAW;
  localparam int C_W = CPP * DATAW;
  localparam int O_W = EPB * DATAW;
  localparam int T_W = M * N * DATAW;
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int QW  = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [WIDW-1:0] wid;
    logic [TAGW-1:0] tag;
    logic [T_W-1:0]  d;
  } ent_t;

  state_t          state, state_nx;
  logic [WIDW-1:0] owner, owner_nx;
  logic [PW-1:0]   exp_q, exp_nx;
  logic [CW-1:0]   occ;
  logic            is_last, occ_full, own_ok;
  logic            fire, in_order;
  logic            store, launch, ooo, pop;

  assign is_last  = in_part == PW'(NUM_PARTS - 1);
  assign occ_full = occ == CW'(OUT_DEPTH);
  assign own_ok   = state == IDLE || in_wid == owner;
  // Only a launching-capable beat waits for a credit.
  assign in_ready = own_ok && !(is_last && occ_full);
  assign fire     = in_valid && in_ready;
  assign in_order = state == IDLE ? in_part == '0
                                  : in_part == exp_q;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    exp_nx   = exp_q;
    store    = 1'b0;
    launch   = 1'b0;
    ooo      = 1'b0;
    if (fire) begin
      unique case (1'b1)
        !in_order: ooo = 1'b1;
        in_order && is_last: begin
          launch   = 1'b1;
          state_nx = IDLE;
        end
        in_order && !is_last: begin
          store    = 1'b1;
          state_nx = LOCKED;
          owner_nx = in_wid;
          exp_nx   = in_part + PW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      exp_q <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      exp_q <= exp_nx;
      err   <= ooo;
    end
  end

  logic [A_W-1:0] a_buf [NUM_PARTS];
  logic [B_W-1:0] b_buf [NUM_PARTS];
  logic [C_W-1:0] c_buf [NUM_PARTS];

  always_ff @(posedge clk) begin
    if (store) begin
      for (int p = 0; p < NUM_PARTS; p++) begin
        if (in_part == PW'(p)) begin
          a_buf[p] <= in_a;
          b_buf[p] <= in_b;
          c_buf[p] <= in_c;
        end
      end
    end
  end

  // Last part comes straight from the live bus.
  logic [T_W-1:0] d_comb;

  always_comb begin
    logic [DATAW-1:0] acc;
    logic [A_W-1:0]   a_s;
    logic [B_W-1:0]   b_s;
    logic [C_W-1:0]   c_s;
    d_comb = '0;
    acc    = '0;
    a_s    = '0;
    b_s    = '0;
    c_s    = '0;
    for (int p = 0; p < NUM_PARTS; p++) begin
      c_s = (p == NUM_PARTS - 1) ? in_c : c_buf[p];
      for (int x = 0; x < CPP; x++)
        d_comb[(p*CPP+x)*DATAW +: DATAW] =
          c_s[x*DATAW +: DATAW];
    end
    for (int p = 0; p < NUM_PARTS; p++) begin
      a_s = (p == NUM_PARTS - 1) ? in_a : a_buf[p];
      b_s = (p == NUM_PARTS - 1) ? in_b : b_buf[p];
      for (int i = 0; i < M; i++) begin
        for (int n = 0; n < N; n++) begin
          acc = d_comb[(i*N+n)*DATAW +: DATAW];
          for (int j = 0; j < KP; j++)
            acc = acc
              + a_s[(i*KP+j)*DATAW +: DATAW]
              * b_s[(j*N+n)*DATAW +: DATAW];
          d_comb[(i*N+n)*DATAW +: DATAW] = acc;
        end
      end
    end
  end

  ent_t l_ent, push_e;
  logic push_v;

  assign l_ent = '{wid: in_wid, tag: in_tag, d: d_comb};

  // Launch edge counts as the first latency cycle; the
  // queue write is the last one.
  if (DPU_LATENCY == 1) begin : g_nopipe
    assign push_v = launch;
    assign push_e = l_ent;
  end else begin : g_pipe
    logic [DPU_LATENCY-2:0] pv;
    ent_t pe [DPU_LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        pv <= '0;
      end else begin
        pv[0] <= launch;
        for (int k = 1; k < DPU_LATENCY - 1; k++)
          pv[k] <= pv[k-1];
      end
    end

    always_ff @(posedge clk) begin
      pe[0] <= l_ent;
      for (int k = 1; k < DPU_LATENCY - 1; k++)
        pe[k] <= pe[k-1];
    end

    assign push_v = pv[DPU_LATENCY-2];
    assign push_e = pe[DPU_LATENCY-2];
  end

  ent_t          q [OUT_DEPTH];
  ent_t          head;
  logic [QW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] q_cnt;
  logic [BW-1:0] beat;

  function automatic logic [QW-1:0] nxt(
    input logic [QW-1:0] p
  );
    return (p == QW'(OUT_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  assign head      = q[rd_ptr];
  assign out_valid = q_cnt != '0;
  assign out_wid   = head.wid;
  assign out_tag   = head.tag;
  assign out_beat  = beat;
  assign out_last  = beat == BW'(WB_BEATS - 1);
  assign pop       = out_valid && out_ready && out_last;
  assign busy      = state == LOCKED || occ != '0;

  always_comb begin
    out_data = '0;
    for (int b = 0; b < WB_BEATS; b++)
      if (beat == BW'(b))
        out_data = head.d[b*O_W +: O_W];
  end

  always_ff @(posedge clk) begin
    if (push_v) q[wr_ptr] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
      occ    <= '0;
      beat   <= '0;
    end else begin
      if (push_v) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      q_cnt <= q_cnt + CW'(push_v) - CW'(pop);
      occ   <= occ + CW'(launch) - CW'(pop);
      if (out_valid && out_ready)
        beat <= out_last ? '0 : beat + BW'(1);
    end
  end

endmodule

// File: tb/tb_vx_tensor_octet_seq.sv
// tb_vx_tensor_octet_seq: vector table plus hand sequences for
// vx_tensor_octet_seq; expected beats queued at launch, checked on output.
module tb_vx_tensor_octet_seq;

  localparam int NP = 2;
  localparam int N  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_wid = '0;
  logic [0:0]   in_part = '0;
  logic [255:0] in_a = '0;
  logic [255:0] in_b = '0;
  logic [255:0] in_c = '0;
  logic [7:0]   in_tag = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [1:0]   out_wid;
  logic [7:0]   out_tag;
  logic [0:0]   out_beat;
  logic         out_last;
  logic [255:0] out_data;
  logic         busy;
  logic         err;

  vx_tensor_octet_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wid(in_wid), .in_part(in_part),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wid(out_wid), .out_tag(out_tag),
    .out_beat(out_beat), .out_last(out_last),
    .out_data(out_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [1:0]  wid;
    logic [7:0]  tag;
    logic [31:0] a0, ar, a1r, b, c0, cr, d0, dr;
  } vec_t;

  typedef struct {
    logic [1:0]   wid;
    logic [7:0]   tag;
    logic         bt;
    logic [255:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vec[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   fire_cyc = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic chk_d(input string nm,
                       input logic [255:0] act,
                       input logic [255:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Chunk p of 8 row-major elements: row 0 gets v0, others vr.
  function automatic logic [255:0] fill(input int p,
                                        input logic [31:0] v0,
                                        input logic [31:0] vr);
    logic [255:0] r;
    r = '0;
    for (int x = 0; x < 8; x++)
      r[x*32 +: 32] = (p * 8 + x < N) ? v0 : vr;
    return r;
  endfunction

  function automatic logic [255:0] sl_a(input vec_t v, input int p);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++)
        r[(i*2+j)*32 +: 32] =
          (i == 0) ? v.a0 : (p == 0 ? v.ar : v.a1r);
    return r;
  endfunction

  task automatic drive(input vec_t v, input logic [1:0] w,
                       input int p);
    in_valid = 1'b1;
    in_wid   = w;
    in_part  = 1'(p);
    in_a     = sl_a(v, p);
    in_b     = {8{v.b}};
    in_c     = fill(p, v.c0, v.cr);
    in_tag   = (p == NP - 1) ? v.tag : ~v.tag;
  endtask

  task automatic send_part(input vec_t v, input logic [1:0] w,
                           input int p, input bit keep);
    exp_t e;
    int n;
    n = 0;
    drive(v, w, p);
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1");
    end else begin
      fire_cyc = cyc;
      if (keep && p == NP - 1) begin
        for (int b = 0; b < 2; b++) begin
          e.wid  = w;
          e.tag  = v.tag;
          e.bt   = 1'(b);
          e.data = fill(b, v.d0, v.dr);
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_group(input vec_t v, input logic [1:0] w);
    send_part(v, w, 0, 1'b1);
    send_part(v, w, 1, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  bit           have_prev = 1'b0;
  logic [255:0] prev_d;
  logic [11:0]  prev_m;

  always @(negedge clk) begin
    exp_t e;
    logic [11:0] m;
    m = {out_wid, out_tag, out_beat, out_last};
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_meta", 64'(m), 64'(prev_m));
        chk_d("hold_data", out_data, prev_d);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got wid=%0d want none",
                   out_wid);
        end else begin
          e = sb.pop_front();
          chk("out_meta", 64'(m),
              64'({e.wid, e.tag, e.bt, e.bt}));
          chk_d("out_data", out_data, e.data);
        end
      end
      have_prev = out_valid && !out_ready;
      prev_d = out_data;
      prev_m = m;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int errs;
    vec[0] = '{wid: 2'd2, tag: 8'h5A,
               a0: 32'd1, ar: 32'd1, a1r: 32'd1, b: 32'd2,
               c0: 32'd3, cr: 32'd3, d0: 32'd11, dr: 32'd11};
    vec[1] = '{wid: 2'd1, tag: 8'h33,
               a0: 32'hFFFFFFFD, ar: 32'hFFFFFFFD,
               a1r: 32'hFFFFFFFD, b: 32'd5,
               c0: 32'd0, cr: 32'd0,
               d0: 32'hFFFFFFC4, dr: 32'hFFFFFFC4};
    vec[2] = '{wid: 2'd0, tag: 8'hC1,
               a0: 32'h7FFFFFFF, ar: 32'd0, a1r: 32'd0,
               b: 32'd2, c0: 32'd2, cr: 32'd0,
               d0: 32'hFFFFFFFA, dr: 32'd0};
    vec[3] = '{wid: 2'd3, tag: 8'h7E,
               a0: 32'd2, ar: 32'd2, a1r: 32'd2,
               b: 32'hFFFFFFFF, c0: 32'd100, cr: 32'd100,
               d0: 32'd92, dr: 32'd92};
    vec[4] = '{wid: 2'd1, tag: 8'h01,
               a0: 32'h10000, ar: 32'd3, a1r: 32'd3,
               b: 32'h10000, c0: 32'd5, cr: 32'hFFFFFFFF,
               d0: 32'd5, dr: 32'hBFFFF};
    vec[5] = '{wid: 2'd3, tag: 8'hA7,
               a0: 32'd0, ar: 32'd1, a1r: 32'd10,
               b: 32'd3, c0: 32'd0, cr: 32'd0,
               d0: 32'd0, dr: 32'h42};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send_part(vec[0], 2'd2, 0, 1'b1);
    send_part(vec[0], 2'd2, 1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", 64'(cyc - fire_cyc), 64'd2);
    wait_drain();
    chk("idle_busy", 64'(busy), 64'd0);

    for (int r = 0; r < 6; r++)
      send_group(vec[r], vec[r].wid);
    wait_drain();

    send_part(vec[1], 2'd0, 0, 1'b1);
    drive(vec[2], 2'd1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("lock_block", 64'(in_ready), 64'd0);
      chk("lock_busy", 64'(busy), 64'd1);
    end
    @(posedge clk);
    #1;
    send_part(vec[1], 2'd0, 1, 1'b1);
    send_part(vec[2], 2'd1, 0, 1'b1);
    send_part(vec[2], 2'd1, 1, 1'b1);
    wait_drain();

    errs = 0;
    send_part(vec[0], 2'd0, 1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (err) errs++;
      chk("ooo_busy", 64'(busy), 64'd0);
    end
    chk("ooo_err_pulses", 64'(errs), 64'd1);
    send_group(vec[3], 2'd0);
    wait_drain();

    out_ready = 1'b0;
    send_group(vec[0], 2'd0);
    send_group(vec[4], 2'd1);
    send_part(vec[5], 2'd3, 0, 1'b1);
    drive(vec[5], 2'd3, 1);
    repeat (4) begin
      @(negedge clk);
      chk("credit_hold", 64'(in_ready), 64'd0);
      chk("credit_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_part(vec[5], 2'd3, 1, 1'b1);
    wait_drain();

    send_group(vec[1], 2'd2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    repeat (8) begin
      @(negedge clk);
      chk("rst_flight_valid", 64'(out_valid), 64'd0);
      chk("rst_flight_busy", 64'(busy), 64'd0);
    end

    send_group(vec[2], 2'd1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
